// File: rtl/frame_stream_reader_if.sv
// Valid/ready byte-stream bundle driven by frame_stream_reader.
// The master drives data/valid/last and the slave returns ready.
interface frame_stream_reader_if #(
    parameter int W = 8
) ();
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/frame_stream_reader.sv
// Snapshots a parallel N-sample frame and drains it lowest index first over a valid/ready stream.
// Define FRAME_CSUM_EN to append a modulo-2^W checksum beat after the last sample.
module frame_stream_reader #(
    parameter int N      = 256,
    parameter int W      = 8,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         frame_in [0:N-1],
    input  logic                 frame_start,
    frame_stream_reader_if.master m_if,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun
);

    localparam int IW = $clog2(N + 1);
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(SETTLE + 1);
`ifdef FRAME_CSUM_EN
    localparam int LAST_BEAT = N;
`else
    localparam int LAST_BEAT = N - 1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STREAM
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    buf_q [0:N-1];
    logic [W-1:0]    buf_d [0:N-1];
    logic [W-1:0]    m_data_q, m_data_d;
    logic            m_valid_q, m_valid_d;
    logic            m_last_q, m_last_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;
    logic            overrun_q, overrun_d;
    logic            snap;
    logic            xfer;
    logic            last_xfer;
`ifdef FRAME_CSUM_EN
    logic [W-1:0]    csum_q, csum_d;
    logic [W-1:0]    frame_sum;
`endif

    assign xfer      = m_valid_q & m_if.m_ready;
    assign last_xfer = xfer & (idx_q == IW'(LAST_BEAT));

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snap         = 1'b0;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = WAIT;
                    cnt_d   = CW'(SETTLE);
                end
            end
            WAIT: begin
                overrun_d = frame_start;
                if (cnt_q == CW'(1)) begin
                    snap    = 1'b1;
                    state_d = STREAM;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STREAM: begin
                // A start coinciding with the final transfer chains the next frame instead of overrunning.
                overrun_d = frame_start & ~last_xfer;
                if (last_xfer) begin
                    frame_done_d = 1'b1;
                    idx_d        = '0;
                    if (frame_start) begin
                        state_d = WAIT;
                        cnt_d   = CW'(SETTLE);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        if (snap) begin
            buf_d = frame_in;
        end else begin
            buf_d = buf_q;
        end
    end

`ifdef FRAME_CSUM_EN
    always_comb begin
        frame_sum = '0;
        for (int i = 0; i < N; i++) begin
            frame_sum = frame_sum + frame_in[i];
        end
        csum_d = snap ? frame_sum : csum_q;
    end
`endif

    // Outputs are computed from next-state values so they leave the flops aligned with the state.
    always_comb begin
        busy_d    = (state_d != IDLE);
        m_valid_d = (state_d == STREAM);
        m_last_d  = m_valid_d & (idx_d == IW'(LAST_BEAT));
        m_data_d  = '0;
        if (m_valid_d) begin
`ifdef FRAME_CSUM_EN
            if (idx_d == IW'(N)) begin
                m_data_d = csum_d;
            end else begin
                m_data_d = buf_d[idx_d[AW-1:0]];
            end
`else
            m_data_d = buf_d[idx_d[AW-1:0]];
`endif
        end
    end

    // NOTE: the frame buffer is plain flops, so it can be cleared on reset like any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
`ifdef FRAME_CSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            buf_q        <= buf_d;
`ifdef FRAME_CSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign m_if.m_data  = m_data_q;
    assign m_if.m_valid = m_valid_q;
    assign m_if.m_last  = m_last_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign overrun      = overrun_q;

    a_stall_hold: assert property (@(posedge clk) disable iff (rst)
        (m_valid_q && !m_if.m_ready) |=> (m_valid_q && $stable(m_data_q) && $stable(m_last_q)));

    a_done_not_streaming: assert property (@(posedge clk) disable iff (rst)
        frame_done_q |-> !m_valid_q);

endmodule

// File: tb/tb_frame_stream_reader.sv
// Scoreboard bench for frame_stream_reader: stimulus queues expected beats, a monitor pops and compares.
// Honours FRAME_CSUM_EN by expecting the extra checksum beat.
module tb_frame_stream_reader;

    localparam int N      = 256;
    localparam int W      = 8;
    localparam int SETTLE = 1;
`ifdef FRAME_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] frame_in [0:N-1];
    logic         frame_start = 1'b0;
    logic         busy;
    logic         frame_done;
    logic         overrun;

    frame_stream_reader_if #(.W(W)) s_if ();

    frame_stream_reader #(.N(N), .W(W), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_in   (frame_in),
        .frame_start(frame_start),
        .m_if       (s_if),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t sb[$];
    int    n_checks   = 0;
    int    n_fail     = 0;
    logic  done_exp   = 1'b0;
    int    ready_mode = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected beats come from the bench's own copy of the frame, taken when the start is issued.
    task automatic push_frame();
        beat_t        b;
        logic [W-1:0] sum;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            b.data = frame_in[i];
            b.last = (i == N - 1) && !CSUM;
            sb.push_back(b);
            sum = sum + frame_in[i];
        end
        if (CSUM) begin
            b.data = sum;
            b.last = 1'b1;
            sb.push_back(b);
        end
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_beat(input logic [W-1:0] val, input bit on_last);
        int k;
        k = 0;
        while (k < 4000) begin
            @(posedge clk); #1;
            if (s_if.m_valid && (on_last ? s_if.m_last : (s_if.m_data == val))) break;
            k++;
        end
        if (k >= 4000) check("wait_beat_timeout", s_if.m_data, val);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 4000) begin
            @(posedge clk);
            k++;
        end
        check("drain_remaining", sb.size(), 0);
        @(posedge clk); #1;
        check("idle_busy", busy, 0);
        check("idle_valid", s_if.m_valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},    s_if.m_data, 0);
        check({tag, "_valid"},   s_if.m_valid, 0);
        check({tag, "_last"},    s_if.m_last, 0);
        check({tag, "_busy"},    busy, 0);
        check({tag, "_done"},    frame_done, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        s_if.m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            s_if.m_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compares every presented beat (stalled or not) against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                done_exp = 1'b0;
            end else begin
                check("frame_done", frame_done, done_exp);
                done_exp = 1'b0;
                if (s_if.m_valid) begin
                    if (sb.size() == 0) begin
                        check("spurious_valid", s_if.m_valid, 0);
                    end else begin
                        check("beat_data", s_if.m_data, sb[0].data);
                        check("beat_last", s_if.m_last, sb[0].last);
                        if (s_if.m_ready) begin
                            done_exp = sb[0].last;
                            void'(sb.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) frame_in[i] = W'(i);

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Ramp frame at full throughput; first valid two cycles after the start.
        push_frame();
        start_frame();
        check("wait_valid", s_if.m_valid, 0);
        check("wait_busy", busy, 1);
        @(posedge clk); #1;
        check("first_valid", s_if.m_valid, 1);
        check("first_data", s_if.m_data, 0);
        wait_drain();

        // Random stalls, and the source frame overwritten after the snapshot.
        ready_mode = 1;
        push_frame();
        start_frame();
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) frame_in[i] = 8'hAA;
        wait_drain();
        ready_mode = 0;
        for (int i = 0; i < N; i++) frame_in[i] = W'(i);

        // Start while streaming is dropped with an overrun pulse.
        push_frame();
        start_frame();
        wait_beat(8'd100, 1'b0);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        check("overrun_pulse", overrun, 1);
        check("overrun_busy", busy, 1);
        @(posedge clk); #1;
        check("overrun_clear", overrun, 0);
        wait_drain();
        repeat (5) @(posedge clk);
        #1;
        check("no_second_frame", busy, 0);

        // Start coincident with the final transfer chains a second frame.
        push_frame();
        start_frame();
        wait_beat(8'd0, 1'b1);
        push_frame();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        check("b2b_overrun", overrun, 0);
        check("b2b_busy", busy, 1);
        check("b2b_done", frame_done, 1);
        check("b2b_wait_valid", s_if.m_valid, 0);
        @(posedge clk); #1;
        check("b2b_first_valid", s_if.m_valid, 1);
        wait_drain();

        // Reset mid-frame aborts without frame_done; a fresh frame follows.
        push_frame();
        start_frame();
        wait_beat(8'd50, 1'b0);
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_abort_busy", busy, 0);
        push_frame();
        start_frame();
        @(posedge clk); #1;
        check("fresh_valid", s_if.m_valid, 1);
        check("fresh_data", s_if.m_data, 0);
        wait_drain();

        // All-ones frame: checksum beat wraps to zero when enabled.
        for (int i = 0; i < N; i++) frame_in[i] = 8'hFF;
        push_frame();
        start_frame();
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_stream_reader.md
Name: frame_stream_reader

Overview:
- Drains a full parallel sample frame, such as the low-pass filter's 256-sample output array, into a byte stream with a valid/ready handshake.
- On a start pulse it waits a fixed settle time, then snapshots the whole frame into an internal buffer.
- It then emits one sample per accepted beat, lowest index first.
- It sits between the frame-parallel filter and downstream serial/streaming logic (UART TX, FIFO, DMA).

Parameters:
- N, 256, samples per frame (>=2).
- W, 8, bits per sample.
- SETTLE, 1, cycles to wait after frame_start before snapshot (>=1); covers the upstream filter's register stage.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- frame_in  in  W x [0:N-1]  parallel frame from upstream filter.
- frame_start  in  1  single-cycle request to capture and stream one frame.
- m_data  out  W  stream sample.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts beat.
- m_last  out  1  marks final beat of frame.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse after the final beat transfers.
- overrun  out  1  one-cycle pulse when a frame_start is dropped.

Behaviour:
- Reset (async, rst=1):
  - State IDLE; sample index and settle counter = 0; internal buffer cleared to 0.
  - m_data=0, m_valid=0, m_last=0, busy=0, frame_done=0, overrun=0.
  - Reset mid-frame aborts the frame immediately; no frame_done is issued.
- States:
  - IDLE: frame_start=1 -> WAIT, settle counter loaded with SETTLE.
  - WAIT: counter decrements each cycle. On the edge where it equals 1, frame_in[0:N-1] is copied into the buffer -> STREAM, index=0.
  - STREAM: m_valid=1, m_data=buf[index], m_last=(index==last beat). Transfer = m_valid & m_ready; each transfer increments index. Transfer of the last beat -> IDLE, frame_done=1 for the following cycle.
- Latency:
  - frame_start high in cycle T; WAIT occupies cycles T+1..T+SETTLE; snapshot taken at the end of cycle T+SETTLE.
  - First m_valid in cycle T+SETTLE+1. With the default, frame_start@0 gives m_valid@2.
  - Full-throughput drain (m_ready held 1) takes N consecutive cycles.
- Handshake:
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
  - m_valid never drops before the last transfer.
  - m_valid is combinationally independent of m_ready.
- Snapshot isolation: frame_in changes after the snapshot edge do not affect streamed data.
- frame_start while busy (WAIT or STREAM): ignored, overrun pulses 1 cycle; the current frame is unaffected.
- Exception: frame_start in the same cycle as the last-beat transfer is accepted. Next state is WAIT (back-to-back frames), not IDLE; busy stays 1; frame_done still pulses; overrun stays 0.
- Index width is $clog2(N+1); no wrap occurs because the index resets on leaving STREAM.

Optional Feature:
- Macro FRAME_CSUM_EN.
- Defined:
  - After sample N-1 the block emits one extra beat carrying the checksum: the modulo-2^W sum of all N snapshotted samples.
  - The checksum accumulates during the snapshot and is held stable like data.
  - m_last is asserted on the checksum beat only; the frame is N+1 beats.
  - frame_done follows the checksum transfer.
- Undefined: N beats, m_last on sample N-1, no checksum logic synthesized.

Test Plan:
- Reset then frame_in[i]=i, frame_start@0, m_ready=1 -> m_valid rises cycle 2; m_data 0,1,...,255 on consecutive cycles; m_last only on 255; frame_done one cycle after; busy low afterwards.
- Same frame with m_ready toggling 1,0,0,1 pseudo-randomly -> every sample delivered exactly once in order; m_data/m_last stable during every stall.
- Change frame_in to all 0xAA two cycles after the snapshot -> stream still carries the original i values.
- frame_start pulsed mid-stream (index 100) -> overrun=1 for one cycle; stream continues 101..255; no second frame. frame_start coincident with the last transfer -> overrun=0, second frame's first m_valid 2 cycles later.
- rst asserted at index 50 with m_valid=1 -> all outputs 0 immediately; no frame_done; a later frame_start streams a fresh frame from index 0.
- FRAME_CSUM_EN defined, frame_in[i]=i -> 257 beats; beat 257 m_data = sum(0..255) mod 256 = 0x80 with m_last=1; all-0xFF frame gives checksum 0x00.
